// File: rtl/mux_seq_pkg.sv
// rtl/mux_seq_pkg.sv - shared types and constants for the mux select sequencer
package mux_seq_pkg;
  typedef enum logic {
    IDLE  = 1'b0,
    DWELL = 1'b1
  } state_e;

  localparam int CH_W   = 2;
  localparam int NUM_CH = 4;
endpackage

// File: rtl/rr_next_ch.sv
// rtl/rr_next_ch.sv - combinational round-robin search for the next enabled channel
module rr_next_ch
  import mux_seq_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   cur,
  output logic [CH_W-1:0]   nxt,
  output logic              wrap,
  output logic              none
);

  logic              found;
  logic [CH_W-1:0]   cand;

  // Offsets 1..NUM_CH; the last offset lands back on cur so a lone channel re-selects itself.
  always_comb begin
    nxt   = cur;
    found = 1'b0;
    cand  = '0;
    none  = (mask == '0);
    for (int i = 1; i <= NUM_CH; i++) begin
      cand = cur + CH_W'(i);
      if (!found && mask[cand]) begin
        nxt   = cand;
        found = 1'b1;
      end
    end
    wrap = found && (nxt <= cur);
  end

endmodule

// File: rtl/mux_select_sequencer.sv
// rtl/mux_select_sequencer.sv - round-robin 4:1 mux select generator with dwell and sampling
module mux_select_sequencer
  import mux_seq_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               en,
  input  logic [NUM_CH-1:0]  mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               f_in,
  output logic               s0,
  output logic               s1,
  output logic               sample_valid,
  output logic               sample_data,
  output logic [CH_W-1:0]    sample_ch,
  output logic [NUM_CH-1:0]  snapshot,
  output logic               scan_done
);

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [CH_W-1:0]    sel_q, sel_d;
  logic               sample_valid_q, sample_valid_d;
  logic               sample_data_q, sample_data_d;
  logic [CH_W-1:0]    sample_ch_q, sample_ch_d;
  logic [NUM_CH-1:0]  snapshot_q, snapshot_d;
  logic               scan_done_q, scan_done_d;

  logic [CH_W-1:0]    rr_cur, rr_nxt;
  logic               rr_wrap, rr_none;

  // From IDLE search from the top channel so the finder yields the lowest set bit.
  assign rr_cur = (state_q == IDLE) ? CH_W'(NUM_CH - 1) : sel_q;

  rr_next_ch u_rr (
    .mask (mask),
    .cur  (rr_cur),
    .nxt  (rr_nxt),
    .wrap (rr_wrap),
    .none (rr_none)
  );

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sel_d          = sel_q;
    sample_valid_d = 1'b0;
    sample_data_d  = sample_data_q;
    sample_ch_d    = sample_ch_q;
    snapshot_d     = snapshot_q;
    scan_done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !rr_none) begin
          sel_d   = rr_nxt;
          cnt_d   = dwell;
          state_d = DWELL;
        end
      end
      DWELL: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          sample_valid_d     = 1'b1;
          sample_data_d      = f_in;
          sample_ch_d        = sel_q;
          snapshot_d[sel_q]  = f_in;
          if (rr_none) begin
            state_d = IDLE;
          end else begin
            sel_d       = rr_nxt;
            cnt_d       = dwell;
            scan_done_d = rr_wrap;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      sel_q          <= '0;
      sample_valid_q <= 1'b0;
      sample_data_q  <= 1'b0;
      sample_ch_q    <= '0;
      snapshot_q     <= '0;
      scan_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sel_q          <= sel_d;
      sample_valid_q <= sample_valid_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      snapshot_q     <= snapshot_d;
      scan_done_q    <= scan_done_d;
    end
  end

  assign s0           = sel_q[0];
  assign s1           = sel_q[1];
  assign sample_valid = sample_valid_q;
  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign snapshot     = snapshot_q;
  assign scan_done    = scan_done_q;

endmodule

// File: tb/tb_mux_select_sequencer.sv
// tb/tb_mux_select_sequencer.sv - table-driven and directed bench for mux_select_sequencer
module tb_mux_select_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic [3:0] mask = 4'b0000;
  logic [7:0] dwell = 8'd0;
  logic       f_in;
  logic       s0, s1, sample_valid, sample_data, scan_done;
  logic [1:0] sample_ch;
  logic [3:0] snapshot;
  logic [3:0] fvec = 4'b0000;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Models the 4:1 mux: f follows the input picked by the current selects.
  always_comb f_in = fvec[{s1, s0}];

  mux_select_sequencer #(.DWELL_W(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .mask         (mask),
    .dwell        (dwell),
    .f_in         (f_in),
    .s0           (s0),
    .s1           (s1),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .snapshot     (snapshot),
    .scan_done    (scan_done)
  );

  typedef struct {
    bit         rst;
    bit         en;
    logic [3:0] mask;
    logic [7:0] dwell;
    logic [3:0] fvec;
    logic [1:0] sel;
    bit         sv;
    bit         sd;
    logic [1:0] sch;
    logic [3:0] snap;
    bit         done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit e, logic [3:0] m, logic [7:0] d, logic [3:0] f,
                              logic [1:0] sel, bit sv, bit sd, logic [1:0] sch,
                              logic [3:0] snap, bit done);
    vec_t v;
    v.rst = rst; v.en = e; v.mask = m; v.dwell = d; v.fvec = f;
    v.sel = sel; v.sv = sv; v.sd = sd; v.sch = sch; v.snap = snap; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] sel, input bit sv, input bit sd,
                          input logic [1:0] sch, input logic [3:0] snap, input bit done,
                          input bit with_data);
    chk({tag, " sel"}, {6'd0, s1, s0}, {6'd0, sel});
    chk({tag, " sample_valid"}, {7'd0, sample_valid}, {7'd0, sv});
    chk({tag, " snapshot"}, {4'd0, snapshot}, {4'd0, snap});
    chk({tag, " scan_done"}, {7'd0, scan_done}, {7'd0, done});
    if (with_data) begin
      chk({tag, " sample_data"}, {7'd0, sample_data}, {7'd0, sd});
      chk({tag, " sample_ch"}, {6'd0, sample_ch}, {6'd0, sch});
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en = 1'b0;
    #2 reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    // Full mask, dwell=2, inputs x0..x3 = 1,0,1,1
    vecs.push_back(mk(1, 0, 4'b1111, 8'd2, 4'b1101, 2'd0, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd0, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd0, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd0, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd1, 1, 1, 2'd0, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd1, 0, 0, 2'd0, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd1, 0, 0, 2'd0, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd2, 1, 0, 2'd1, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd2, 0, 0, 2'd0, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd2, 0, 0, 2'd0, 4'b0001, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd3, 1, 1, 2'd2, 4'b0101, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd3, 0, 0, 2'd0, 4'b0101, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd3, 0, 0, 2'd0, 4'b0101, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd0, 1, 1, 2'd3, 4'b1101, 1));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd0, 0, 0, 2'd0, 4'b1101, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd0, 0, 0, 2'd0, 4'b1101, 0));
    vecs.push_back(mk(0, 1, 4'b1111, 8'd2, 4'b1101, 2'd1, 1, 1, 2'd0, 4'b1101, 0));
    // mask=1010, dwell=0: alternates 1,3 every cycle
    vecs.push_back(mk(1, 0, 4'b1010, 8'd0, 4'b1111, 2'd0, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 8'd0, 4'b1111, 2'd1, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 8'd0, 4'b1111, 2'd3, 1, 1, 2'd1, 4'b0010, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 8'd0, 4'b1111, 2'd1, 1, 1, 2'd3, 4'b1010, 1));
    vecs.push_back(mk(0, 1, 4'b1010, 8'd0, 4'b1111, 2'd3, 1, 1, 2'd1, 4'b1010, 0));
    vecs.push_back(mk(0, 1, 4'b1010, 8'd0, 4'b1111, 2'd1, 1, 1, 2'd3, 4'b1010, 1));
    // Single channel 2, dwell=1
    vecs.push_back(mk(1, 0, 4'b0100, 8'd1, 4'b0100, 2'd0, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 8'd1, 4'b0100, 2'd2, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 8'd1, 4'b0100, 2'd2, 0, 0, 2'd0, 4'b0000, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 8'd1, 4'b0100, 2'd2, 1, 1, 2'd2, 4'b0100, 1));
    vecs.push_back(mk(0, 1, 4'b0100, 8'd1, 4'b0100, 2'd2, 0, 0, 2'd0, 4'b0100, 0));
    vecs.push_back(mk(0, 1, 4'b0100, 8'd1, 4'b0100, 2'd2, 1, 1, 2'd2, 4'b0100, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      mask  = vecs[i].mask;
      dwell = vecs[i].dwell;
      fvec  = vecs[i].fvec;
      if (vecs[i].rst) begin
        do_reset();
      end else begin
        en = vecs[i].en;
        tick();
      end
      chk_outs($sformatf("row%0d", i), vecs[i].sel, vecs[i].sv, vecs[i].sd, vecs[i].sch,
               vecs[i].snap, vecs[i].done, vecs[i].sv || vecs[i].rst);
    end

    // Asynchronous reset while holding ch2 with counter=3 and pulses active
    do_reset();
    mask = 4'b0100; dwell = 8'd0; fvec = 4'b0100; en = 1'b1;
    tick();
    dwell = 8'd3;
    tick();
    chk_outs("arst_pre", 2'd2, 1, 1, 2'd2, 4'b0100, 1, 1);
    #2 reset_n = 1'b0;
    #1;
    chk_outs("arst_async", 2'd0, 0, 0, 2'd0, 4'b0000, 0, 1);
    en = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    tick();
    chk_outs("arst_idle", 2'd0, 0, 0, 2'd0, 4'b0000, 0, 1);
    en = 1'b1;
    tick();
    chk_outs("arst_entry", 2'd2, 0, 0, 2'd0, 4'b0000, 0, 0);

    // en dropped in the 2nd cycle of a dwell=4 hold on ch2, then restart from ch1
    do_reset();
    mask = 4'b0110; dwell = 8'd0; fvec = 4'b1111; en = 1'b1;
    tick();
    dwell = 8'd4;
    tick();
    chk_outs("endrop_ch2", 2'd2, 1, 1, 2'd1, 4'b0010, 0, 1);
    tick();
    en = 1'b0;
    tick();
    chk_outs("endrop_idle", 2'd2, 0, 0, 2'd0, 4'b0010, 0, 0);
    tick();
    chk_outs("endrop_hold", 2'd2, 0, 0, 2'd0, 4'b0010, 0, 0);
    en = 1'b1;
    tick();
    chk_outs("endrop_restart", 2'd1, 0, 0, 2'd0, 4'b0010, 0, 0);
    for (int k = 0; k < 4; k++) tick();
    chk_outs("endrop_last_hold", 2'd1, 0, 0, 2'd0, 4'b0010, 0, 0);
    tick();
    chk_outs("endrop_sample", 2'd2, 1, 1, 2'd1, 4'b0010, 0, 1);

    // mask cleared mid-dwell on ch1: sample still delivered, then IDLE with selects held
    do_reset();
    mask = 4'b1111; dwell = 8'd2; fvec = 4'b0010; en = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    chk_outs("mclr_ch0", 2'd1, 1, 0, 2'd0, 4'b0000, 0, 1);
    tick();
    mask = 4'b0000;
    tick();
    tick();
    chk_outs("mclr_sample", 2'd1, 1, 1, 2'd1, 4'b0010, 0, 1);
    tick();
    chk_outs("mclr_idle", 2'd1, 0, 1, 2'd1, 4'b0010, 0, 1);
    tick();
    chk_outs("mclr_idle2", 2'd1, 0, 1, 2'd1, 4'b0010, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
